// File: rtl/markov_pkg.sv
// Shared helpers for the Markov von Neumann extractor: lane count, pointer width
// and the legal-parameter predicate.
package markov_pkg;

    function automatic int lane_count(input int order);
        return 32'sd1 << order;
    endfunction

    // Pointer carries one extra bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    function automatic bit params_legal(input int order, input int out_w, input int depth);
        return (order >= 32'sd1) && (order <= 32'sd6) &&
               (out_w >= 32'sd2) && (out_w <= 32'sd64) &&
               (depth >= 32'sd2) && (depth <= 32'sd256) &&
               ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO is
// visible on rdata one cycle after the write edge.
module sync_fifo
    import markov_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [ptr_width(DEPTH)-1:0] count
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r, rd_ptr_r, count_r, count_nx_s, rd_nx_s;
    logic [WIDTH-1:0] rdata_r, head_nx_s;
    logic             full_r, empty_r, push_s, pop_s;

    // Next-state: accepted push/pop, next count and the next head word
    always_comb begin
        pop_s      = pop && !empty_r;
        push_s     = push && (!full_r || pop_s);
        rd_nx_s    = pop_s ? (rd_ptr_r + 1'b1) : rd_ptr_r;
        count_nx_s = count_r;
        if (push_s && !pop_s) begin
            count_nx_s = count_r + 1'b1;
        end else if (pop_s && !push_s) begin
            count_nx_s = count_r - 1'b1;
        end else begin
            count_nx_s = count_r;
        end
        if (count_nx_s == '0) begin
            head_nx_s = '0;
        end else if (push_s && ((count_r == '0) || ((count_r == PW'(1)) && pop_s))) begin
            head_nx_s = wdata;
        end else begin
            head_nx_s = mem_r[rd_nx_s[AW-1:0]];
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Pointers, occupancy and registered status/head outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            rdata_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            rd_ptr_r <= rd_nx_s;
            count_r  <= count_nx_s;
            rdata_r  <= head_nx_s;
            full_r   <= (count_nx_s == PW'(DEPTH));
            empty_r  <= (count_nx_s == '0);
        end
    end

    assign rdata = rdata_r;
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/markov_vn_extractor.sv
// Markov-conditioned von Neumann debiaser: bits are split into lanes by their
// ORDER-bit history, debiased per lane, packed LSB-first and queued.
module markov_vn_extractor
    import markov_pkg::*;
#(
    parameter int ORDER = 4,
    parameter int OUT_W = 16,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_in,
    input  logic                        bit_valid,
    output logic [ORDER-1:0]            lane,
    output logic                        warm,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ptr_width(DEPTH)-1:0] fifo_count,
    output logic [15:0]                 drop_count
);
    localparam int LANES = lane_count(ORDER);
    localparam int WCW   = $clog2(ORDER + 1);
    localparam int CW    = $clog2(OUT_W);

    if (!params_legal(ORDER, OUT_W, DEPTH)) begin : g_bad_params
        $error("markov_vn_extractor: illegal parameter set");
    end

    logic [ORDER-1:0] hist_r, hist_nx_s;
    logic             warm_r;
    logic [WCW-1:0]   wcnt_r;
    logic [LANES-1:0] pend_r, pbit_r;
    logic [OUT_W-2:0] asm_r;
    logic [CW-1:0]    cnt_r;
    logic [15:0]      drop_r;
    logic             emit_s, emit_bit_s, word_done_s, pop_s, drop_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [OUT_W-1:0] word_s;

    // Lane pairing decision and word completion for the current bit
    always_comb begin
        hist_nx_s  = ORDER'({hist_r, bit_in});
        emit_bit_s = pbit_r[hist_r];
        if (bit_valid && warm_r && pend_r[hist_r] && (pbit_r[hist_r] != bit_in)) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
        word_done_s = emit_s && (cnt_r == CW'(OUT_W - 1));
        word_s      = {emit_bit_s, asm_r};
        pop_s       = !fifo_empty_s && out_ready;
        drop_s      = word_done_s && fifo_full_s && !pop_s;
    end

    // History shift, warm-up count and per-lane pending state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= '0;
            warm_r <= 1'b0;
            wcnt_r <= '0;
            pend_r <= '0;
            pbit_r <= '0;
        end else if (bit_valid) begin
            hist_r <= hist_nx_s;
            if (!warm_r) begin
                wcnt_r <= wcnt_r + 1'b1;
                warm_r <= (wcnt_r == WCW'(ORDER - 1));
            end else if (pend_r[hist_r]) begin
                pend_r[hist_r] <= 1'b0;
            end else begin
                pend_r[hist_r] <= 1'b1;
                pbit_r[hist_r] <= bit_in;
            end
        end
    end

    // Word assembler and saturating overflow counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_r  <= '0;
            cnt_r  <= '0;
            drop_r <= 16'h0000;
        end else begin
            if (word_done_s) begin
                asm_r <= '0;
                cnt_r <= '0;
            end else if (emit_s) begin
                asm_r[cnt_r] <= emit_bit_s;
                cnt_r        <= cnt_r + 1'b1;
            end
            if (drop_s && (drop_r != 16'hFFFF)) begin
                drop_r <= drop_r + 16'h0001;
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (word_done_s),
        .pop   (out_ready),
        .wdata (word_s),
        .rdata (out_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    assign lane       = hist_r;
    assign warm       = warm_r;
    assign out_valid  = !fifo_empty_s;
    assign drop_count = drop_r;

endmodule

// File: tb/tb_markov_vn_extractor.sv
// Scoreboard bench for markov_vn_extractor with ORDER=1, OUT_W=4, DEPTH=4.
module tb_markov_vn_extractor;
    localparam int ORDER = 1;
    localparam int OUT_W = 4;
    localparam int DEPTH = 4;
    localparam int LANES = 2;

    logic             clk, reset, bit_in, bit_valid, out_ready;
    logic [ORDER-1:0] lane;
    logic             warm, out_valid;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       fifo_count;
    logic [15:0]      drop_count;

    markov_vn_extractor #(.ORDER(ORDER), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .lane(lane), .warm(warm), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int               m_wcnt;
    logic [ORDER-1:0] m_hist;
    bit               m_pend [LANES];
    bit               m_pbit [LANES];
    bit               m_bits [$];
    logic [OUT_W-1:0] q [$];
    int               m_drops;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wcnt = 0;
        m_hist = '0;
        for (int i = 0; i < LANES; i++) begin
            m_pend[i] = 1'b0;
            m_pbit[i] = 1'b0;
        end
        m_bits.delete();
        q.delete();
        m_drops = 0;
    endtask

    function automatic bit will_emit(input bit b);
        if (m_wcnt < ORDER) return 1'b0;
        return m_pend[m_hist] && (m_pbit[m_hist] != b);
    endfunction

    // One clock: check state left by the previous edge, drive inputs, advance model.
    task automatic step(input bit v, input bit b, input bit rdy);
        logic [OUT_W-1:0] w;
        int l;
        @(negedge clk);
        check_eq("valid", out_valid, q.size() != 0);
        check_eq("count", fifo_count, q.size());
        check_eq("drops", drop_count, m_drops);
        check_eq("lane", lane, m_hist);
        check_eq("warm", warm, m_wcnt >= ORDER);
        bit_valid = v;
        bit_in    = b;
        out_ready = rdy;
        if (rdy && q.size() != 0) begin
            check_eq("pop_data", out_data, q.pop_front());
        end
        if (v) begin
            if (m_wcnt < ORDER) begin
                m_wcnt++;
            end else begin
                l = int'(m_hist);
                if (!m_pend[l]) begin
                    m_pend[l] = 1'b1;
                    m_pbit[l] = b;
                end else begin
                    if (m_pbit[l] != b) m_bits.push_back(m_pbit[l]);
                    m_pend[l] = 1'b0;
                end
            end
            m_hist = ORDER'({m_hist, b});
            if (m_bits.size() == OUT_W) begin
                w = '0;
                for (int i = 0; i < OUT_W; i++) w[i] = m_bits[i];
                m_bits.delete();
                if (q.size() < DEPTH) q.push_back(w);
                else if (m_drops < 65535) m_drops++;
            end
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, rdy);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_lane"}, lane, 0);
        check_eq({tag, "_warm"}, warm, 0);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_data"}, out_data, 0);
        check_eq({tag, "_count"}, fifo_count, 0);
        check_eq({tag, "_drops"}, drop_count, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit seq [] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit b, done;
        reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        model_reset();

        // first bits: warm after one bit, one emitted 1 on the 4th bit
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("warm_first", warm, 1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("asm_cnt", dut.cnt_r, 1);
        check_eq("asm_bit0", dut.asm_r[0], 1);
        check_eq("first_valid", out_valid, 0);

        // constant stream never emits
        apply_reset();
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, 1'b0);
        idle(1'b0);
        check_eq("const_valid", out_valid, 0);
        check_eq("const_drops", drop_count, 0);

        // emits 1,0,1,1 -> 4'b1101, visible the cycle after the write edge
        apply_reset();
        foreach (seq[i]) step(1'b1, seq[i], 1'b0);
        idle(1'b0);
        check_eq("word_valid", out_valid, 1);
        check_eq("word_data", out_data, 4'b1101);
        idle(1'b1);
        idle(1'b0);

        // overflow: 6 words with no reader -> 4 held, 2 dropped, drained in order
        apply_reset();
        for (int i = 0; i < 3000 && !(q.size() == DEPTH && m_drops == 2); i++)
            step(1'b1, 1'(($urandom_range(0, 1))), 1'b0);
        check_eq("ovf_reach", (q.size() == DEPTH && m_drops == 2), 1);
        idle(1'b0);
        check_eq("ovf_count", fifo_count, 4);
        check_eq("ovf_drops", drop_count, 2);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        idle(1'b0);

        // full FIFO popped on the completing edge: no drop
        apply_reset();
        for (int i = 0; i < 3000 && q.size() < DEPTH; i++)
            step(1'b1, 1'(($urandom_range(0, 1))), 1'b0);
        check_eq("full_reach", q.size(), DEPTH);
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            b = 1'($urandom_range(0, 1));
            if (will_emit(b) && m_bits.size() == OUT_W - 1) begin
                step(1'b1, b, 1'b1);
                done = 1'b1;
            end else begin
                step(1'b1, b, 1'b0);
            end
        end
        check_eq("full_hit", done, 1);
        idle(1'b0);
        check_eq("full_count", fifo_count, 4);
        check_eq("full_drops", drop_count, 0);

        // asynchronous reset mid-word with 2 words queued
        apply_reset();
        for (int i = 0; i < 3000 && !(q.size() == 2 && m_bits.size() > 0); i++)
            step(1'b1, 1'(($urandom_range(0, 1))), 1'b0);
        check_eq("mid_reach", (q.size() == 2 && m_bits.size() > 0), 1);
        idle(1'b0);
        check_eq("mid_count", fifo_count, 2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        idle(1'b0);
        check_eq("rewarm", warm, 1);
        check_eq("rewarm_pend", dut.pend_r, 0);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/markov_vn_extractor.md
MARKOV_VN_EXTRACTOR -- requirements
Module: markov_vn_extractor

Interface
REQ-001 SHALL have parameter ORDER, default 4: Markov history length in bits; lanes = 2^ORDER; legal range 1..6.
REQ-002 SHALL have parameter OUT_W, default 16: output word width; legal range 2..64.
REQ-003 SHALL have parameter DEPTH, default 16: output FIFO depth in words; power of two, 2..256.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port bit_in, input, 1: raw entropy bit.
REQ-007 SHALL have port bit_valid, input, 1: bit_in is consumed on every edge where this is high; there is no backpressure.
REQ-008 SHALL have port lane, output, ORDER: current history register, which selects the lane for the next bit.
REQ-009 SHALL have port warm, output, 1: high once ORDER bits have been consumed since reset.
REQ-010 SHALL have port out_data, output, OUT_W: head word of the FIFO.
REQ-011 SHALL have port out_valid, output, 1: FIFO is non-empty.
REQ-012 SHALL have port out_ready, input, 1: a word is popped on an edge where out_valid and out_ready are both high.
REQ-013 SHALL have port fifo_count, output, $clog2(DEPTH)+1: number of words held.
REQ-014 SHALL have port drop_count, output, 16: words dropped on overflow; saturates at 16'hFFFF.

Function
REQ-015 SHALL shift history on each consumed bit: hist <= {hist[ORDER-2:0], bit_in}; for ORDER=1, hist <= bit_in.
REQ-016 SHALL, while warm=0, only shift history and count warm-up bits; lanes stay untouched.
REQ-017 SHALL give each lane a pending flag and a pending bit; the consumed bit is routed to lane = hist value before the shift.
REQ-018 SHALL apply von Neumann pairing per lane: pending=0 -> store the bit and set pending; pending=1 and bits differ -> emit the pending bit and clear pending; pending=1 and bits equal -> discard and clear pending.
REQ-019 SHALL assemble emitted bits LSB-first into an OUT_W-bit register with a bit counter.
REQ-020 SHALL, on the edge that supplies the OUT_W-th bit, write {new_bit, asm[OUT_W-2:0]} into the FIFO and zero the counter in that same edge.
REQ-021 SHALL present a written word on out_data with out_valid high in the cycle after the write edge (first-word latency 1 cycle).
REQ-022 SHALL, when the FIFO is full and not popping on the write edge, drop the word and increment drop_count; the counter still resets.
REQ-023 SHALL treat push and pop on the same edge when full as legal with no drop; the count stays DEPTH.
REQ-024 SHALL treat push and pop on the same edge when empty as a push only.
REQ-025 SHALL treat a pop with out_valid=0 as a no-op.
REQ-026 SHALL wrap FIFO read and write pointers modulo DEPTH, using an extra bit to tell full from empty.

Reset
REQ-027 SHALL, on reset assertion and irrespective of clk, clear: hist=0, warm=0, warm-up counter, all lane pending flags and bits, assembler and its counter, FIFO pointers, fifo_count=0, out_valid=0, out_data=0, drop_count=0.
REQ-028 SHALL lose a partially assembled word and all FIFO contents when reset is asserted mid-operation.

Structure
REQ-029 SHALL place the lane count function, the parameter range checks and the pointer-width helper in package markov_pkg.
REQ-030 SHALL implement the FIFO as sub-module sync_fifo (parametrised WIDTH and DEPTH, asynchronous active-high reset, full/empty/count outputs).

Verification (ORDER=1, OUT_W=4, DEPTH=4 unless stated)
REQ-031 SHALL cover: reset, then bits 0,1,0,0 -> warm=1 after the first bit; exactly one emitted bit =1 on the 4th bit; counter=1; out_valid=0.
REQ-032 SHALL cover: constant-1 stream of 1000 bits -> out_valid stays 0 and drop_count=0.
REQ-033 SHALL cover: a pattern producing 4 emitted bits 1,0,1,1 -> out_data=4'b1101 with out_valid high exactly 1 cycle after the 4th emit edge.
REQ-034 SHALL cover: out_ready=0 while 6 words complete -> fifo_count=4, drop_count=2, and the first 4 words are popped in order.
REQ-035 SHALL cover: FIFO full with out_ready=1 on the edge a word completes -> no drop, fifo_count stays 4.
REQ-036 SHALL cover: reset asserted between edges mid-word with 2 words queued -> all outputs at reset values immediately, and warm-up restarts.
